// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared state encodings, default header and baud-divider helper
// for the UART packet receiver.
package uart_pkt_pkg;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
   typedef enum logic [1:0] {P_HDR_HI, P_HDR_LO, P_PAYLOAD, P_CSUM} pkt_state_t;

   localparam logic [15:0] DEFAULT_HEADER = 16'hBACD;

   // Clock cycles per UART bit (integer division).
   function automatic int calc_bit_ticks(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_packet_rx_byte_rx.sv
// uart_byte_rx: 2-FF synchroniser plus 8N1 byte deserialiser. Emits a one-cycle
// byte strobe (with the byte) on a good stop bit, or a frame strobe when the
// stop bit samples low.
module uart_byte_rx
   import uart_pkt_pkg::*;
#(
   parameter int BIT_TICKS = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_stb,
   output logic       frame_stb
);

   localparam int HALF_M1 = (BIT_TICKS / 2 > 1) ? BIT_TICKS / 2 - 1 : 0;
   localparam int CW      = ($clog2(BIT_TICKS) < 1) ? 1 : $clog2(BIT_TICKS);
   localparam logic [CW-1:0] LIM_BIT  = CW'(BIT_TICKS - 1);
   localparam logic [CW-1:0] LIM_HALF = CW'(HALF_M1);

   logic [1:0]  sync;
   logic        rx_s;
   byte_state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        tick_done;

   assign rx_s    = sync[1];
   assign rx_byte = shreg;

   // Two-flop synchroniser; idles high so reset does not look like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], rx};
   end

   // START waits half a bit to land mid start bit; other states wait a full bit.
   assign tick_done = (cnt == ((state == B_START) ? LIM_HALF : LIM_BIT));

   // Next-state logic for the byte FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         B_IDLE:  if (!rx_s) state_nxt = B_START;
         B_START: if (tick_done) state_nxt = rx_s ? B_IDLE : B_DATA;
         B_DATA:  if (tick_done && bit_cnt == 3'd7) state_nxt = B_STOP;
         B_STOP:  if (tick_done) state_nxt = B_IDLE;
         default: state_nxt = B_IDLE;
      endcase
   end

   // State register, bit timer, shifter and strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= B_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_stb  <= 1'b0;
         frame_stb <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= (state == B_IDLE || tick_done) ? '0 : cnt + 1'b1;
         byte_stb  <= (state == B_STOP) && tick_done && rx_s;
         frame_stb <= (state == B_STOP) && tick_done && !rx_s;
         if (state == B_START) bit_cnt <= '0;
         if (state == B_DATA && tick_done) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: hunts for a 16-bit header in a UART byte stream, collects
// NUM_WORDS x WORD_BYTES payload bytes, checks a mod-256 checksum and hands
// verified packets out on a valid/ready port. Dropped packets are counted.
// Optional macro UART_PKT_RX_TIMEOUT_EN adds an inter-byte gap timeout.
module uart_packet_rx
   import uart_pkt_pkg::*;
#(
   parameter int          CLK_FREQ     = 100000000,
   parameter int          BAUD_RATE    = 115200,
   parameter logic [15:0] HEADER       = DEFAULT_HEADER,
   parameter int          NUM_WORDS    = 2,
   parameter int          WORD_BYTES   = 8,
   parameter int          TIMEOUT_BITS = 20
) (
   input  logic                              clk,
   input  logic                              rst_i,
   input  logic                              rx_i,
   output logic [NUM_WORDS*WORD_BYTES*8-1:0] pkt_data_o,
   output logic                              pkt_valid_o,
   input  logic                              pkt_ready_i,
   output logic                              csum_err_o,
   output logic                              frame_err_o,
   output logic                              overrun_o,
   output logic [7:0]                        err_cnt_o
);

   localparam int BIT_TICKS = calc_bit_ticks(CLK_FREQ, BAUD_RATE);
   localparam int NB        = NUM_WORDS * WORD_BYTES;
   localparam int CNTW      = ($clog2(NB) < 1) ? 1 : $clog2(NB);
   localparam logic [CNTW-1:0] LAST    = CNTW'(NB - 1);
   localparam logic [7:0]      HDR_SUM = HEADER[15:8] + HEADER[7:0];

   logic [1:0]          rst_pipe;
   logic                rst;
   logic [7:0]          rx_byte;
   logic                byte_stb, frame_stb;
   pkt_state_t          state, state_nxt;
   logic [CNTW-1:0]     cnt, widx;
   logic [7:0]          sum;
   logic [NB-1:0][7:0]  stage;
   logic                hdr_ok, wr, good, bad, frame_drop, timeout;
   logic                accept, load, overrun, drop;

   // Reset asserts asynchronously and releases two clocks after rst_i drops.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst = rst_pipe[1];

   uart_byte_rx #(.BIT_TICKS(BIT_TICKS)) u_byte (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx_i),
      .rx_byte   (rx_byte),
      .byte_stb  (byte_stb),
      .frame_stb (frame_stb)
   );

`ifdef UART_PKT_RX_TIMEOUT_EN
   localparam int GAP_LIM = TIMEOUT_BITS * BIT_TICKS;
   localparam int GW      = $clog2(GAP_LIM + 2);
   logic [GW-1:0] gap;

   // Cycles since the last good byte; saturates just past the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         gap <= '0;
      else if (byte_stb)               gap <= '0;
      else if (gap <= GW'(GAP_LIM))    gap <= gap + 1'b1;
   end

   assign timeout = (state != P_HDR_HI) && (gap > GW'(GAP_LIM)) && !byte_stb && !frame_stb;
`else
   assign timeout = 1'b0;
`endif

   // Payload byte 0 lands in the top byte lane so word 0 ends up in the MS bits.
   assign widx = LAST - cnt;

   // Packet FSM next state plus per-strobe events.
   always_comb begin
      state_nxt  = state;
      hdr_ok     = 1'b0;
      wr         = 1'b0;
      good       = 1'b0;
      bad        = 1'b0;
      frame_drop = 1'b0;
      if (frame_stb) begin
         frame_drop = (state == P_PAYLOAD) || (state == P_CSUM);
         state_nxt  = P_HDR_HI;
      end else if (byte_stb) begin
         case (state)
            P_HDR_HI: if (rx_byte == HEADER[15:8]) state_nxt = P_HDR_LO;
            P_HDR_LO: begin
               if (rx_byte == HEADER[7:0]) begin
                  state_nxt = P_PAYLOAD;
                  hdr_ok    = 1'b1;
               end else if (rx_byte != HEADER[15:8]) begin
                  state_nxt = P_HDR_HI;
               end
            end
            P_PAYLOAD: begin
               wr = 1'b1;
               if (cnt == LAST) state_nxt = P_CSUM;
            end
            P_CSUM: begin
               state_nxt = P_HDR_HI;
               if (rx_byte == sum) good = 1'b1;
               else                bad  = 1'b1;
            end
            default: state_nxt = P_HDR_HI;
         endcase
      end else if (timeout) begin
         state_nxt = P_HDR_HI;
      end
   end

   assign accept  = pkt_valid_o && pkt_ready_i;
   assign load    = good && (!pkt_valid_o || accept);
   assign overrun = good && pkt_valid_o && !accept;
   assign drop    = bad || overrun || frame_drop || timeout;

   // Packet FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= P_HDR_HI;
      else     state <= state_nxt;
   end

   // Staging buffer, byte index and running checksum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         sum   <= '0;
         stage <= '0;
      end else if (hdr_ok) begin
         cnt <= '0;
         sum <= HDR_SUM;
      end else if (wr) begin
         stage[widx] <= rx_byte;
         sum         <= sum + rx_byte;
         cnt         <= cnt + 1'b1;
      end
   end

   // Output register, handshake, error pulses and saturating drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_data_o  <= '0;
         pkt_valid_o <= 1'b0;
         csum_err_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         err_cnt_o   <= '0;
      end else begin
         csum_err_o  <= bad;
         frame_err_o <= frame_stb;
         overrun_o   <= overrun;
         if (load) begin
            pkt_data_o  <= stage;
            pkt_valid_o <= 1'b1;
         end else if (accept) begin
            pkt_valid_o <= 1'b0;
         end
         if (drop && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx with an expected-packet scoreboard.
module tb_uart_packet_rx;

   localparam int CLK_FREQ = 400000;
   localparam int BAUD     = 100000;
   localparam int BT       = CLK_FREQ / BAUD;
   localparam int NB       = 16;
   localparam int DW       = NB * 8;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          rx_i;
   logic          pkt_ready_i;
   logic [DW-1:0] pkt_data_o;
   logic          pkt_valid_o, csum_err_o, frame_err_o, overrun_o;
   logic [7:0]    err_cnt_o;

   always #5 clk = ~clk;

   uart_packet_rx #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .HEADER(16'hBACD),
      .NUM_WORDS(2), .WORD_BYTES(8), .TIMEOUT_BITS(20)
   ) u_dut (
      .clk(clk), .rst_i(rst_i), .rx_i(rx_i),
      .pkt_data_o(pkt_data_o), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
      .csum_err_o(csum_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
      .err_cnt_o(err_cnt_o)
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int n_csum = 0, n_frame = 0, n_ovr = 0;
   int cyc = 0, stb_cyc = 0, last_lat = -1;
   logic vld_d = 1'b0;

   // Monitor: records accepted packets, error pulses and valid-rise latency.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (u_dut.u_byte.byte_stb) stb_cyc = cyc;
      if (pkt_valid_o && !vld_d) last_lat = cyc - stb_cyc;
      vld_d = pkt_valid_o;
      if (pkt_valid_o && pkt_ready_i) got_q.push_back(pkt_data_o);
      n_csum  = n_csum + int'(csum_err_o);
      n_frame = n_frame + int'(frame_err_o);
      n_ovr   = n_ovr + int'(overrun_o);
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic v);
      rx_i = v;
      repeat (BT) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      if (!stop) repeat (12) send_bit(1'b1);
   endtask

   function automatic logic [7:0] csum_of(input logic [DW-1:0] p);
      logic [7:0] s;
      s = 8'hBA + 8'hCD;
      for (int i = 0; i < NB; i++) s = s + p[DW-1-8*i -: 8];
      return s;
   endfunction

   task automatic send_pkt(input logic [DW-1:0] p, input logic [7:0] cs);
      send_byte(8'hBA);
      send_byte(8'hCD);
      for (int i = 0; i < NB; i++) send_byte(p[DW-1-8*i -: 8]);
      send_byte(cs);
   endtask

   // Waits (bounded) for a delivered packet and compares it with the oldest expectation.
   task automatic expect_pkt(input string tag);
      int k;
      logic [DW-1:0] e, g;
      k = 0;
      while (got_q.size() == 0 && k < 200) begin
         tick();
         k++;
      end
      chk({tag, "_arrived"}, DW'(got_q.size() > 0), DW'(1));
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk(tag, g, e);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) tick();
      rst_i = 1'b0;
      repeat (4) tick();
   endtask

   logic [DW-1:0] p1, p2, p3, pa, pb;
   int n0;

   initial begin
      p1 = {64'h1, 64'h2};
      p2 = {64'hDEADBEEF_01234567, 64'h89ABCDEF_FEDCBA98};
      p3 = {64'h0011223344556677, 64'h8899AABBCCDDEEFF};
      pa = {64'hA5A5A5A5_00000001, 64'h5A5A5A5A_00000002};
      pb = {64'hFFFFFFFF_FFFFFFFF, 64'h12345678_9ABCDEF0};
      rst_i = 1'b1; rx_i = 1'b1; pkt_ready_i = 1'b1;
      repeat (3) tick();
      // reset state
      chk("rst_valid", DW'(pkt_valid_o), DW'(0));
      chk("rst_data", pkt_data_o, '0);
      chk("rst_errcnt", DW'(err_cnt_o), DW'(0));
      chk("rst_pulses", DW'({csum_err_o, frame_err_o, overrun_o}), DW'(0));
      rst_i = 1'b0;
      repeat (5) tick();

      // good packet, ready high
      exp_q.push_back(p1);
      send_pkt(p1, 8'h8A);
      expect_pkt("good_pkt");
      chk("good_latency", DW'(last_lat), DW'(1));
      chk("good_errcnt", DW'(err_cnt_o), DW'(0));
      tick();
      chk("good_valid_drop", DW'(pkt_valid_o), DW'(0));

      // checksum error then recovery
      n0 = n_csum;
      send_pkt(p1, 8'h8B);
      repeat (5) tick();
      chk("csum_pulse", DW'(n_csum - n0), DW'(1));
      chk("csum_no_pkt", DW'(got_q.size()), DW'(0));
      chk("csum_errcnt", DW'(err_cnt_o), DW'(1));
      exp_q.push_back(p2);
      send_pkt(p2, csum_of(p2));
      expect_pkt("after_csum_pkt");

      // noise and resync BA BA CD
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'hBA);
      exp_q.push_back(p3);
      send_pkt(p3, csum_of(p3));
      expect_pkt("resync_pkt");
      chk("resync_errcnt", DW'(err_cnt_o), DW'(1));

      // backpressure and overrun
      do_reset();
      pkt_ready_i = 1'b0;
      n0 = n_ovr;
      send_pkt(pa, csum_of(pa));
      send_pkt(pb, csum_of(pb));
      repeat (5) tick();
      chk("bp_valid", DW'(pkt_valid_o), DW'(1));
      chk("bp_data_held", pkt_data_o, pa);
      chk("bp_overrun", DW'(n_ovr - n0), DW'(1));
      chk("bp_errcnt", DW'(err_cnt_o), DW'(1));
      exp_q.push_back(pa);
      pkt_ready_i = 1'b1;
      expect_pkt("bp_accept");
      tick();
      chk("bp_valid_drop", DW'(pkt_valid_o), DW'(0));
      chk("bp_no_extra", DW'(got_q.size()), DW'(0));

      // framing error in payload byte 5
      do_reset();
      n0 = n_frame;
      send_byte(8'hBA);
      send_byte(8'hCD);
      for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
      send_byte(8'h45, 1'b0);
      chk("frame_pulse", DW'(n_frame - n0), DW'(1));
      chk("frame_errcnt", DW'(err_cnt_o), DW'(1));
      exp_q.push_back(p2);
      send_pkt(p2, csum_of(p2));
      expect_pkt("after_frame_pkt");

      // async reset mid-payload with a pending packet
      do_reset();
      pkt_ready_i = 1'b0;
      send_pkt(p3, csum_of(p3));
      send_pkt(p1, 8'h00);
      send_byte(8'hBA);
      send_byte(8'hCD);
      for (int i = 0; i < 3; i++) send_byte(8'(i));
      chk("pre_rst_valid", DW'(pkt_valid_o), DW'(1));
      chk("pre_rst_errcnt", DW'(err_cnt_o), DW'(1));
      #1;
      rst_i = 1'b1;
      #1;
      chk("async_rst_valid", DW'(pkt_valid_o), DW'(0));
      chk("async_rst_data", pkt_data_o, '0);
      chk("async_rst_errcnt", DW'(err_cnt_o), DW'(0));
      tick();
      rst_i = 1'b0;
      pkt_ready_i = 1'b1;
      repeat (4) tick();

`ifdef UART_PKT_RX_TIMEOUT_EN
      // partial packet abandoned by the gap timeout
      send_byte(8'hBA);
      send_byte(8'hCD);
      for (int i = 0; i < 3; i++) send_byte(8'(i));
      repeat (25 * BT) tick();
      chk("timeout_errcnt", DW'(err_cnt_o), DW'(1));
      exp_q.push_back(p1);
      send_pkt(p1, 8'h8A);
      expect_pkt("after_timeout_pkt");
      do_reset();
`endif

      // drop counter saturation
      for (int n = 0; n < 255; n++) begin
         send_byte(8'hBA);
         send_byte(8'hCD);
         send_byte(8'h00, 1'b0);
      end
      chk("sat_255", DW'(err_cnt_o), DW'(255));
      send_byte(8'hBA);
      send_byte(8'hCD);
      send_byte(8'h00, 1'b0);
      chk("sat_hold", DW'(err_cnt_o), DW'(255));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
